// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and the data-memory bus.
// Issues one request/grant/response access per instruction and stalls until done.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_cut,
    input  logic [1:0]  reg_cut,
    input  logic        ext_os,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;
    localparam logic [1:0] W_BAD  = 2'b11;

    localparam logic [1:0] F_NONE = 2'b00;
    localparam logic [1:0] F_MIS  = 2'b01;
    localparam logic [1:0] F_WID  = 2'b10;
    localparam logic [1:0] F_TMO  = 2'b11;

    localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic             is_load_q, is_load_d;
    logic [1:0]       width_q, width_d;
    logic             ext_q, ext_d;
    logic [1:0]       off_q, off_d;
    logic [29:0]      waddr_q, waddr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      ldata_q, ldata_d;

    logic             req;
    logic [1:0]       sel_w;
    logic [1:0]       req_code;
    logic [3:0]       req_be;
    logic [31:0]      req_wdata;
    logic             tmo;

    // Pick the lane out of the read word and widen it to 32 bits.
    function automatic logic [31:0] extract(
        input logic [31:0] rd,
        input logic [1:0]  w,
        input logic [1:0]  off,
        input logic        sx
    );
        logic [31:0] bsh;
        logic [31:0] hsh;
        logic [31:0] r;
        bsh = rd >> {off, 3'b000};
        hsh = rd >> {off[1], 4'b0000};
        case (w)
            W_BYTE:  r = {{24{sx & bsh[7]}}, bsh[7:0]};
            W_HALF:  r = {{16{sx & hsh[15]}}, hsh[15:0]};
            default: r = rd;
        endcase
        return r;
    endfunction

    assign req   = mem_read | mem_write;
    assign sel_w = mem_read ? mem_cut : reg_cut;
    assign tmo   = TMO_EN && (cnt_q == CNT_LAST);

    // Decode the incoming request: fault class, byte enables and write lanes.
    always_comb begin
        req_code  = F_NONE;
        req_be    = 4'b1111;
        req_wdata = store_data;
        if ((mem_read && mem_write) || (sel_w == W_BAD)) begin
            req_code = F_WID;
        end else if ((sel_w == W_HALF && addr[0]) ||
                     (sel_w == W_WORD && addr[1:0] != 2'b00)) begin
            req_code = F_MIS;
        end
        unique case (sel_w)
            W_BYTE: begin
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {4{store_data[7:0]}};
            end
            W_HALF: begin
                req_be    = 4'b0011 << {addr[1], 1'b0};
                req_wdata = {2{store_data[15:0]}};
            end
            W_WORD: begin
                req_be    = 4'b1111;
                req_wdata = store_data;
            end
            W_BAD: begin
                req_be    = 4'b0000;
                req_wdata = store_data;
            end
        endcase
    end

    // Next-state logic for the access sequencer and its datapath registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        is_load_d = is_load_q;
        width_d   = width_q;
        ext_d     = ext_q;
        off_d     = off_q;
        waddr_d   = waddr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        ldata_d   = ldata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    is_load_d = mem_read;
                    width_d   = sel_w;
                    ext_d     = ext_os;
                    off_d     = addr[1:0];
                    waddr_d   = addr[31:2];
                    be_d      = req_be;
                    wdata_d   = req_wdata;
                    code_d    = req_code;
                    if (req_code != F_NONE) begin
                        state_d = DONE;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    if (is_load_q) begin
                        state_d = WAIT_R;
                        cnt_d   = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else if (tmo) begin
                    code_d  = F_TMO;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_R: begin
                if (bus_rvalid) begin
                    ldata_d = extract(bus_rdata, width_q, off_q, ext_q);
                    state_d = DONE;
                end else if (tmo) begin
                    code_d  = F_TMO;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, timeout counter and fault code registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= F_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Latched request attributes and the returned load value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_load_q <= 1'b0;
            width_q   <= W_WORD;
            ext_q     <= 1'b0;
            off_q     <= 2'b00;
            waddr_q   <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            ldata_q   <= '0;
        end else begin
            is_load_q <= is_load_d;
            width_q   <= width_d;
            ext_q     <= ext_d;
            off_q     <= off_d;
            waddr_q   <= waddr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            ldata_q   <= ldata_d;
        end
    end

    // Pipeline and bus outputs; bus fields are only driven while requesting.
    always_comb begin
        stall      = 1'b0;
        bus_req    = (state_q == REQ);
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_be     = 4'b0000;
        bus_wdata  = '0;
        load_valid = 1'b0;
        fault      = 1'b0;
        fault_code = F_NONE;
        if (rst_n) begin
            unique case (state_q)
                IDLE:   stall = req;
                REQ:    stall = 1'b1;
                WAIT_R: stall = 1'b1;
                DONE:   stall = 1'b0;
            endcase
        end
        if (bus_req) begin
            bus_we    = ~is_load_q;
            bus_addr  = {waddr_q, 2'b00};
            bus_be    = be_q;
            bus_wdata = wdata_q;
        end
        if (state_q == DONE) begin
            load_valid = is_load_q && (code_q == F_NONE);
            fault      = (code_q != F_NONE);
            fault_code = code_q;
        end
    end

    assign load_data = ldata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl.
// Stimulus queues expected bus/response items; monitors pop and compare.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, ext_os;
    logic [1:0]  mem_cut, reg_cut;
    logic [31:0] addr, store_data;
    logic        stall, load_valid, fault;
    logic [31:0] load_data;
    logic [1:0]  fault_code;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    typedef struct {
        logic        flt;
        logic [1:0]  code;
        logic [31:0] data;
    } resp_t;

    bus_t  bq[$];
    resp_t rq[$];

    lsu_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_cut(mem_cut), .reg_cut(reg_cut), .ext_os(ext_os),
        .addr(addr), .store_data(store_data),
        .stall(stall), .load_valid(load_valid), .load_data(load_data),
        .fault(fault), .fault_code(fault_code),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic exp_bus(input logic we, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
        bus_t b;
        b.we = we; b.a = a; b.be = be; b.wd = wd;
        bq.push_back(b);
    endtask

    task automatic exp_resp(input logic flt, input logic [1:0] code,
                            input logic [31:0] data);
        resp_t r;
        r.flt = flt; r.code = code; r.data = data;
        rq.push_back(r);
    endtask

    // Response monitor: every load_valid/fault pulse must match the queue head.
    always @(negedge clk) begin
        if (load_valid || fault) begin
            if (rq.size() == 0) begin
                chk("unexpected_resp", 32'({load_valid, fault}), 32'd0);
            end else begin
                resp_t e;
                e = rq.pop_front();
                chk("resp_fault", 32'(fault), 32'(e.flt));
                chk("resp_valid", 32'(load_valid), 32'(!e.flt));
                chk("resp_code", 32'(fault_code), 32'(e.code));
                if (!e.flt) chk("resp_data", load_data, e.data);
            end
        end
    end

    // Bus monitor: every granted request must match the queue head.
    always @(negedge clk) begin
        #2;
        if (bus_req && bus_gnt) begin
            if (bq.size() == 0) begin
                chk("unexpected_bus", 32'(bus_req), 32'd0);
            end else begin
                bus_t e;
                e = bq.pop_front();
                chk("bus_we", 32'(bus_we), 32'(e.we));
                chk("bus_addr", bus_addr, e.a);
                chk("bus_be", 32'(bus_be), 32'(e.be));
                if (e.we) chk("bus_wdata", bus_wdata, e.wd);
            end
        end
    end

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; mem_cut = 0; reg_cut = 0;
        ext_os = 0; addr = 0; store_data = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 32'hA5A5_A5A5;
    endtask

    // One instruction; call at a negedge. gd = REQ cycles before grant.
    task automatic access(input string nm,
                          input logic mr, input logic mw,
                          input logic [1:0] mc, input logic [1:0] rc,
                          input logic ex, input logic [31:0] a,
                          input logic [31:0] sd, input int gd,
                          input bit rv_on, input bit early,
                          input logic [31:0] rd,
                          input int exp_stall, input int exp_req);
        int stalls = 0;
        int reqs   = 0;
        int rcnt   = 0;
        int cyc    = 0;
        bit granted = 0;
        mem_read = mr; mem_write = mw; mem_cut = mc; reg_cut = rc;
        ext_os = ex; addr = a; store_data = sd;
        while (cyc < 40) begin
            #1;
            if (!stall) break;
            stalls++;
            if (bus_req) reqs++;
            bus_gnt = bus_req && (rcnt == gd);
            if (bus_req) rcnt++;
            if (granted && !bus_req && rv_on) begin
                bus_rvalid = 1; bus_rdata = rd;
            end else if (early && bus_gnt) begin
                bus_rvalid = 1; bus_rdata = 32'hA5A5_A5A5;
            end else begin
                bus_rvalid = 0; bus_rdata = 32'hA5A5_A5A5;
            end
            if (bus_gnt) granted = 1;
            @(negedge clk);
            cyc++;
        end
        idle_inputs();
        chk({nm, "_bound"}, 32'(cyc < 40), 32'd1);
        chk({nm, "_stall"}, stalls, exp_stall);
        chk({nm, "_req"}, reqs, exp_req);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rc;
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", 32'({stall, load_valid, fault, fault_code,
                               bus_req, bus_we, bus_be}), 32'd0);
        chk("reset_bus", bus_addr | bus_wdata, 32'd0);
        chk("reset_ldata", load_data, 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        exp_bus(1, 32'h100, 4'b1111, 32'hDEAD_BEEF);
        access("sw", 0, 1, 2'b00, 2'b00, 0, 32'h100, 32'hDEAD_BEEF,
               0, 1, 0, 0, 2, 1);

        exp_bus(0, 32'h200, 4'b1000, 0);
        exp_resp(0, 2'b00, 32'hFFFF_FF80);
        access("lb_sx", 1, 0, 2'b10, 2'b00, 1, 32'h203, 0,
               0, 1, 1, 32'h80FF_FFFF, 3, 1);

        exp_bus(0, 32'h200, 4'b1000, 0);
        exp_resp(0, 2'b00, 32'h0000_0080);
        access("lb_zx", 1, 0, 2'b10, 2'b00, 0, 32'h203, 0,
               0, 1, 0, 32'h80FF_FFFF, 3, 1);

        exp_bus(1, 32'h100, 4'b1100, 32'hABCD_ABCD);
        access("sh", 0, 1, 2'b00, 2'b01, 0, 32'h102, 32'h1234_ABCD,
               0, 1, 0, 0, 2, 1);

        exp_resp(1, 2'b01, 0);
        access("lh_mis", 1, 0, 2'b01, 2'b00, 1, 32'h101, 0,
               0, 1, 0, 0, 1, 0);

        exp_resp(1, 2'b10, 0);
        access("ld_w11", 1, 0, 2'b11, 2'b00, 0, 32'h10, 0,
               0, 1, 0, 0, 1, 0);

        exp_resp(1, 2'b10, 0);
        access("rd_wr", 1, 1, 2'b00, 2'b00, 0, 32'h10, 0,
               0, 1, 0, 0, 1, 0);

        exp_resp(1, 2'b10, 0);
        access("st_w11", 0, 1, 2'b00, 2'b11, 0, 32'h20, 32'h5,
               0, 1, 0, 0, 1, 0);

        exp_resp(1, 2'b01, 0);
        access("lw_mis", 1, 0, 2'b00, 2'b00, 0, 32'h106, 0,
               0, 1, 0, 0, 1, 0);

        exp_bus(0, 32'h100, 4'b1100, 0);
        exp_resp(0, 2'b00, 32'hFFFF_8001);
        access("lh_hi", 1, 0, 2'b01, 2'b00, 1, 32'h102, 0,
               1, 1, 0, 32'h8001_7FFF, 4, 2);

        exp_bus(0, 32'h200, 4'b0010, 0);
        exp_resp(0, 2'b00, 32'h0000_0056);
        access("lb_l1", 1, 0, 2'b10, 2'b00, 1, 32'h201, 0,
               0, 1, 0, 32'h1234_56F0, 3, 1);

        exp_bus(1, 32'h300, 4'b0100, 32'hA7A7_A7A7);
        access("sb", 0, 1, 2'b00, 2'b10, 0, 32'h302, 32'h0000_00A7,
               0, 1, 0, 0, 2, 1);
        chk("ldata_hold", load_data, 32'h0000_0056);

        exp_bus(0, 32'h100, 4'b0011, 0);
        exp_resp(0, 2'b00, 32'h0000_8001);
        access("lhu_lo", 1, 0, 2'b01, 2'b00, 0, 32'h100, 0,
               0, 1, 0, 32'h0000_8001, 3, 1);

        exp_resp(1, 2'b11, 0);
        access("tmo_req", 1, 0, 2'b00, 2'b00, 0, 32'h40, 0,
               99, 1, 0, 0, 5, 4);

        exp_bus(0, 32'h44, 4'b1111, 0);
        exp_resp(1, 2'b11, 0);
        access("tmo_rd", 1, 0, 2'b00, 2'b00, 0, 32'h44, 0,
               0, 0, 0, 0, 6, 1);

        exp_bus(0, 32'h20, 4'b1111, 0);
        mem_read = 1; mem_cut = 2'b00; addr = 32'h20;
        rc = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (bus_req) begin
                bus_gnt = (rc == 3);
                rc++;
            end else begin
                bus_gnt = 0;
            end
            if (!bus_req && rc > 3) break;
            @(negedge clk);
        end
        chk("mid_wait_stall", 32'(stall), 32'd1);
        rst_n = 0;
        #1;
        chk("mid_rst_ctrl", 32'({stall, load_valid, fault, fault_code,
                                 bus_req, bus_we, bus_be}), 32'd0);
        chk("mid_rst_bus", bus_addr | bus_wdata, 32'd0);
        chk("mid_rst_ldata", load_data, 32'd0);
        repeat (2) @(negedge clk);
        idle_inputs();
        rst_n = 1;
        repeat (2) @(negedge clk);

        exp_bus(0, 32'h8, 4'b1111, 0);
        exp_resp(0, 2'b00, 32'h1122_3344);
        access("lw_post", 1, 0, 2'b00, 2'b00, 0, 32'h8, 0,
               0, 1, 0, 32'h1122_3344, 3, 1);

        repeat (3) @(negedge clk);
        chk("resp_queue_empty", rq.size(), 32'd0);
        chk("bus_queue_empty", bq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
